// File: rtl/hcsr04_emulator.sv
// HC-SR04 responder: accepts a trig pulse and returns an echo whose width encodes distance_cm.
// Optional macro HCSR04_JITTER_EN adds 0..15 cycles of LFSR jitter and a jitter_seed port.
module hcsr04_emulator #(
   parameter int TRIG_MIN_CYCLES    = 500,
   parameter int BURST_DELAY_CYCLES = 25000,
   parameter int CYCLES_PER_CM      = 2900,
   parameter int MAX_RANGE_CM       = 400,
   parameter int TIMEOUT_CYCLES     = 1900000,
   parameter int HOLDOFF_CYCLES     = 50000,
   parameter int DIST_W             = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              trig,
   input  logic [DIST_W-1:0] distance_cm,
   input  logic              object_present,
`ifdef HCSR04_JITTER_EN
   input  logic [15:0]       jitter_seed,
`endif
   output logic              echo,
   output logic              busy,
   output logic              trig_err
);

   // One counter serves every phase, so it must hold the largest span plus jitter headroom.
   localparam int MAX_PROD = MAX_RANGE_CM * CYCLES_PER_CM;
   localparam int M1       = (TIMEOUT_CYCLES > MAX_PROD) ? TIMEOUT_CYCLES : MAX_PROD;
   localparam int M2       = (M1 > BURST_DELAY_CYCLES) ? M1 : BURST_DELAY_CYCLES;
   localparam int M3       = (M2 > HOLDOFF_CYCLES) ? M2 : HOLDOFF_CYCLES;
   localparam int M4       = (M3 > TRIG_MIN_CYCLES) ? M3 : TRIG_MIN_CYCLES;
   localparam int M5       = (M4 > (1 << DIST_W)) ? M4 : (1 << DIST_W);
   localparam int CNT_W    = $clog2(M5 + 17);

   typedef enum logic [2:0] {
      S_IDLE,
      S_TRIG_HI,
      S_BURST,
      S_ECHO,
      S_HOLDOFF
   } state_t;

   state_t             r_state;
   logic [1:0]         r_sync;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   r_width;
   logic [DIST_W-1:0]  r_dist;
   logic               r_obj;
   logic               r_echo;
   logic               r_busy;
   logic               r_trig_err;

   logic               w_trig_s;
   logic               w_timeout;
   logic [CNT_W-1:0]   w_dist_eff;
   logic [CNT_W-1:0]   w_jit;
   logic [CNT_W-1:0]   w_width;

   assign w_trig_s = r_sync[1];
   assign echo     = r_echo;
   assign busy     = r_busy;
   assign trig_err = r_trig_err;

`ifdef HCSR04_JITTER_EN
   logic [15:0] r_lfsr;
   logic [15:0] w_seed;
   logic [15:0] w_lfsr_next;

   assign w_seed      = (jitter_seed == 16'h0000) ? 16'hACE1 : jitter_seed;
   assign w_lfsr_next = {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
   assign w_jit       = CNT_W'(r_lfsr[3:0]);
`else
   assign w_jit       = '0;
`endif

   always_comb begin
      w_timeout  = !r_obj || (CNT_W'(r_dist) > CNT_W'(MAX_RANGE_CM));
      w_dist_eff = (r_dist == '0) ? CNT_W'(1) : CNT_W'(r_dist);
      w_width    = CNT_W'(TIMEOUT_CYCLES);
      if (!w_timeout) begin
         w_width = (w_dist_eff * CNT_W'(CYCLES_PER_CM)) + w_jit;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_sync <= 2'b00;
      end else begin
         r_sync <= {r_sync[0], trig};
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_width    <= '0;
         r_dist     <= '0;
         r_obj      <= 1'b0;
         r_echo     <= 1'b0;
         r_busy     <= 1'b0;
         r_trig_err <= 1'b0;
`ifdef HCSR04_JITTER_EN
         r_lfsr     <= w_seed;
`endif
      end else begin
         r_trig_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_trig_s) begin
                  r_state <= S_TRIG_HI;
                  r_cnt   <= CNT_W'(1);
               end
            end
            S_TRIG_HI: begin
               if (w_trig_s) begin
                  if (r_cnt < CNT_W'(TRIG_MIN_CYCLES)) begin
                     r_cnt <= r_cnt + CNT_W'(1);
                  end
               end else if (r_cnt >= CNT_W'(TRIG_MIN_CYCLES)) begin
                  r_state <= S_BURST;
                  r_cnt   <= '0;
                  r_dist  <= distance_cm;
                  r_obj   <= object_present;
                  r_busy  <= 1'b1;
`ifdef HCSR04_JITTER_EN
                  r_lfsr  <= w_lfsr_next;
`endif
               end else begin
                  r_state    <= S_IDLE;
                  r_cnt      <= '0;
                  r_trig_err <= 1'b1;
               end
            end
            S_BURST: begin
               // Counting to BURST_DELAY_CYCLES (not -1) lands the echo edge on delay+3 after the raw fall.
               r_width <= w_width;
               if (r_cnt == CNT_W'(BURST_DELAY_CYCLES)) begin
                  r_state <= S_ECHO;
                  r_echo  <= 1'b1;
                  r_cnt   <= CNT_W'(1);
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_ECHO: begin
               if (r_cnt == r_width) begin
                  r_state <= S_HOLDOFF;
                  r_echo  <= 1'b0;
                  r_cnt   <= CNT_W'(1);
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            S_HOLDOFF: begin
               if (r_cnt == CNT_W'(HOLDOFF_CYCLES)) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_cnt   <= '0;
               r_echo  <= 1'b0;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_hcsr04_emulator.sv
// Directed bench for hcsr04_emulator with small timing parameters and hand-computed expectations.
module tb_hcsr04_emulator;

   logic       clk;
   logic       rst;
   logic       trig;
   logic [8:0] distance_cm;
   logic       object_present;
   logic       echo;
   logic       busy;
   logic       trig_err;

   int total;
   int bad;

   hcsr04_emulator #(
      .TRIG_MIN_CYCLES   (5),
      .BURST_DELAY_CYCLES(20),
      .CYCLES_PER_CM     (10),
      .MAX_RANGE_CM      (400),
      .TIMEOUT_CYCLES    (5000),
      .HOLDOFF_CYCLES    (50),
      .DIST_W            (9)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .trig          (trig),
      .distance_cm   (distance_cm),
      .object_present(object_present),
      .echo          (echo),
      .busy          (busy),
      .trig_err      (trig_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Raw trig is high for n sampling edges; returns just after the edge preceding the first low sample.
   task automatic pulse_trig(input int n);
      @(posedge clk); #1;
      trig = 1'b1;
      repeat (n) @(posedge clk);
      #1;
      trig = 1'b0;
   endtask

   // k counts edges after trig fall: first low sample is k=1, so echo rises at k = 1 + 20 + 3 = 24.
   task automatic measure(input bit disturb, output int rise_k, output int width,
                          output int hold, output int errs, output int busy_gap);
      int k;
      int k2;
      rise_k = -1; width = 0; hold = -1; errs = 0; busy_gap = 0;
      k = 0;
      while (rise_k < 0 && k < 300) begin
         @(posedge clk); #1;
         k++;
         if (trig_err) errs++;
         if (disturb && k == 5) distance_cm = 9'd100;
         if (echo) rise_k = k;
      end
      if (rise_k >= 0) begin
         width = 1;
         if (!busy) busy_gap++;
         while (echo && width < 6000) begin
            @(posedge clk); #1;
            if (trig_err) errs++;
            if (disturb) begin
               if (width == 50) trig = 1'b1;
               if (width == 60) trig = 1'b0;
               if (width == 70) trig = 1'b1;
               if (width == 72) trig = 1'b0;
            end
            if (echo) begin
               width++;
               if (!busy) busy_gap++;
            end
         end
         k2 = 0;
         while (busy && k2 < 200) begin
            @(posedge clk); #1;
            k2++;
            if (trig_err) errs++;
            if (disturb) begin
               if (k2 == 5)  trig = 1'b1;
               if (k2 == 15) trig = 1'b0;
            end
         end
         hold = busy ? -1 : k2;
      end
   endtask

   task automatic test_reset();
      rst = 1'b0; trig = 1'b0; distance_cm = 9'd25; object_present = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      total++; if (echo !== 1'b0) begin bad++; $display("FAIL reset_echo: got %b want 0", echo); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", busy); end
      total++; if (trig_err !== 1'b0) begin bad++; $display("FAIL reset_trig_err: got %b want 0", trig_err); end
      rst = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_nominal();
      int r, w, h, e, g;
      distance_cm = 9'd25; object_present = 1'b1;
      pulse_trig(10);
      measure(1'b0, r, w, h, e, g);
      total++; if (r !== 24) begin bad++; $display("FAIL nominal_rise: got %0d want 24", r); end
      total++; if (w !== 250) begin bad++; $display("FAIL nominal_width: got %0d want 250", w); end
      total++; if (h !== 50) begin bad++; $display("FAIL nominal_holdoff: got %0d want 50", h); end
      total++; if (e !== 0) begin bad++; $display("FAIL nominal_trig_err: got %0d want 0", e); end
      total++; if (g !== 0) begin bad++; $display("FAIL nominal_busy_gap: got %0d want 0", g); end
   endtask

   task automatic test_short_trigger();
      int errs, echos, busys;
      errs = 0; echos = 0; busys = 0;
      pulse_trig(3);
      repeat (60) begin
         @(posedge clk); #1;
         if (trig_err) errs++;
         if (echo) echos++;
         if (busy) busys++;
      end
      total++; if (errs !== 1) begin bad++; $display("FAIL short_trig_err: got %0d want 1", errs); end
      total++; if (echos !== 0) begin bad++; $display("FAIL short_echo: got %0d want 0", echos); end
      total++; if (busys !== 0) begin bad++; $display("FAIL short_busy: got %0d want 0", busys); end
   endtask

   task automatic test_no_target();
      int r, w, h, e, g;
      distance_cm = 9'd25; object_present = 1'b0;
      pulse_trig(10);
      measure(1'b0, r, w, h, e, g);
      total++; if (r !== 24) begin bad++; $display("FAIL notarget_rise: got %0d want 24", r); end
      total++; if (w !== 5000) begin bad++; $display("FAIL notarget_width: got %0d want 5000", w); end
      distance_cm = 9'd401; object_present = 1'b1;
      pulse_trig(10);
      measure(1'b0, r, w, h, e, g);
      total++; if (w !== 5000) begin bad++; $display("FAIL outofrange_width: got %0d want 5000", w); end
      total++; if (h !== 50) begin bad++; $display("FAIL outofrange_holdoff: got %0d want 50", h); end
   endtask

   task automatic test_latch_ignore();
      int r, w, h, e, g;
      int echos, busys;
      distance_cm = 9'd25; object_present = 1'b1;
      pulse_trig(10);
      measure(1'b1, r, w, h, e, g);
      total++; if (w !== 250) begin bad++; $display("FAIL latch_width: got %0d want 250", w); end
      total++; if (e !== 0) begin bad++; $display("FAIL ignore_trig_err: got %0d want 0", e); end
      total++; if (h !== 50) begin bad++; $display("FAIL ignore_holdoff: got %0d want 50", h); end
      echos = 0; busys = 0;
      repeat (100) begin
         @(posedge clk); #1;
         if (echo) echos++;
         if (busy) busys++;
      end
      total++; if (echos !== 0) begin bad++; $display("FAIL ignore_no_echo: got %0d want 0", echos); end
      total++; if (busys !== 0) begin bad++; $display("FAIL ignore_no_busy: got %0d want 0", busys); end
      pulse_trig(10);
      measure(1'b0, r, w, h, e, g);
      total++; if (w !== 1000) begin bad++; $display("FAIL latch_next_width: got %0d want 1000", w); end
   endtask

   task automatic test_boundary();
      int r, w, h, e, g;
      distance_cm = 9'd0; object_present = 1'b1;
      pulse_trig(5);
      measure(1'b0, r, w, h, e, g);
      total++; if (r !== 24) begin bad++; $display("FAIL min_trig_rise: got %0d want 24", r); end
      total++; if (w !== 10) begin bad++; $display("FAIL dist0_width: got %0d want 10", w); end
      distance_cm = 9'd400;
      pulse_trig(10);
      measure(1'b0, r, w, h, e, g);
      total++; if (w !== 4000) begin bad++; $display("FAIL dist400_width: got %0d want 4000", w); end
   endtask

   task automatic test_reset_mid_echo();
      int r, w, h, e, g;
      int k;
      distance_cm = 9'd25; object_present = 1'b1;
      pulse_trig(10);
      k = 0;
      while (!echo && k < 300) begin
         @(posedge clk); #1;
         k++;
      end
      repeat (100) @(posedge clk);
      #1;
      total++; if (echo !== 1'b1) begin bad++; $display("FAIL midecho_echo_before: got %b want 1", echo); end
      #2;
      rst = 1'b0;
      #1;
      total++; if (echo !== 1'b0) begin bad++; $display("FAIL midecho_async_echo: got %b want 0", echo); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL midecho_async_busy: got %b want 0", busy); end
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      pulse_trig(10);
      measure(1'b0, r, w, h, e, g);
      total++; if (r !== 24) begin bad++; $display("FAIL after_reset_rise: got %0d want 24", r); end
      total++; if (w !== 250) begin bad++; $display("FAIL after_reset_width: got %0d want 250", w); end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_nominal();
      test_short_trigger();
      test_no_target();
      test_latch_ignore();
      test_boundary();
      test_reset_mid_echo();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/hcsr04_emulator.md
Name: hcsr04_emulator

Overview:
- Synthesizable model of the HC-SR04 ultrasonic ranger: the responder end of the trig/echo protocol.
- Accepts a trigger pulse and returns an echo pulse whose width encodes a programmed distance.
- Used for hardware-in-loop and simulation checkout of the proximity sensor driver without a physical sensor.
- Sits on the same trig/echo wires the driver uses; the distance is set from switches or a bench.

Parameters:
- TRIG_MIN_CYCLES, 500: minimum trig high width, in clk cycles, for a valid trigger (10 us at 50 MHz).
- BURST_DELAY_CYCLES, 25000: delay from accepted trig fall to echo rise; models the 8x40 kHz burst.
- CYCLES_PER_CM, 2900: echo cycles per cm (58 us/cm at 50 MHz).
- MAX_RANGE_CM, 400: largest reportable distance.
- TIMEOUT_CYCLES, 1900000: echo width when no object or out of range (38 ms).
- HOLDOFF_CYCLES, 50000: dead time after echo fall before a new trigger is accepted.
- DIST_W, 9: width of distance_cm.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- trig  in  1  trigger from the driver; asynchronous, 2-flop synchronized internally.
- distance_cm  in  DIST_W  target distance in cm; sampled once per measurement.
- object_present  in  1  0 = no echo target; forces a timeout-width echo.
- echo  out  1  echo pulse to the driver; registered.
- busy  out  1  high from accepted trigger until holdoff ends.
- trig_err  out  1  one-cycle pulse when a trig high phase is shorter than TRIG_MIN_CYCLES.

Behaviour:
- Reset (rst=0, async): state IDLE; echo=0, busy=0, trig_err=0; all counters and latches cleared; synchronizer flops cleared.
- trig_s is the output of the 2-flop synchronizer. All state logic uses trig_s only.
- IDLE:
  - trig_s=1 → TRIG_HI; width counter set to 1.
- TRIG_HI:
  - Counter increments each cycle while trig_s=1 and saturates at TRIG_MIN_CYCLES.
  - On trig_s=0 with counter ≥ TRIG_MIN_CYCLES → BURST. On that edge, latch distance_cm and object_present and assert busy.
  - On trig_s=0 with counter < TRIG_MIN_CYCLES → IDLE, and trig_err pulses high for exactly one cycle.
- BURST:
  - Count BURST_DELAY_CYCLES, then → ECHO with echo=1.
  - Echo rises exactly BURST_DELAY_CYCLES+3 rising edges after the first edge at which raw trig is sampled 0 (2 synchronizer stages + 1 state register).
- ECHO:
  - echo stays high for exactly W cycles, then drops to 0 → HOLDOFF.
  - W = latched_dist × CYCLES_PER_CM.
  - W = TIMEOUT_CYCLES if latched object_present=0 or latched_dist > MAX_RANGE_CM.
  - latched_dist = 0 is treated as 1 cm.
  - Compute the product in a counter at least ceil(log2(TIMEOUT_CYCLES+1)) bits wide; it must not overflow.
- HOLDOFF:
  - Count HOLDOFF_CYCLES, then → IDLE with busy=0.
- trig activity in BURST, ECHO or HOLDOFF is ignored: no restart, no trig_err.
- trig already high on return to IDLE: treated as a new rising edge; width is counted from IDLE entry.
- Changes to distance_cm or object_present after the latch have no effect on the measurement in progress.
- Async reset mid-measurement: echo drops to 0 immediately (asynchronously); state returns to IDLE.
- One measurement in flight at a time; no queuing.

Optional Feature:
- Macro: HCSR04_JITTER_EN.
- Defined:
  - A 16-bit maximal LFSR (x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset) advances once per accepted trigger.
  - Its low 4 bits (0..15) are added to W for that measurement, except on timeout-width echoes.
  - Adds a jitter_seed input port (16 bits), loaded into the LFSR on reset instead of 16'hACE1; a zero seed is replaced by 16'hACE1.
- Not defined: no LFSR, no jitter_seed port; W is exact as specified above.

Test Plan:
All scenarios use TRIG_MIN_CYCLES=5, BURST_DELAY_CYCLES=20, CYCLES_PER_CM=10, MAX_RANGE_CM=400, TIMEOUT_CYCLES=5000, HOLDOFF_CYCLES=50, jitter disabled.
- Nominal: distance_cm=25, object_present=1, trig high 10 cycles → echo rises 23 cycles after trig fall, stays high exactly 250 cycles; busy high throughout; trig_err never pulses.
- Short trigger: trig high 3 cycles → exactly one trig_err pulse; echo stays 0; busy stays 0.
- No target / out of range: object_present=0 with distance 25, then object_present=1 with distance_cm=401 → each echo is 5000 cycles wide.
- Latch and ignore: change distance_cm 25→100 during BURST, and toggle trig during ECHO and HOLDOFF → echo width 250; no second echo until a trigger after HOLDOFF; that trigger yields width 1000.
- Boundary distances: distance_cm=0 → width 10; distance_cm=400 → width 4000.
- Reset mid-echo: assert rst 100 cycles into echo → echo=0 and busy=0 at once; after release, a nominal trigger measures correctly.
